multicycle_control_fsm: RTL and testbench

- Multicycle CPU control unit. Walks each instruction through fetch/decode/execute/memory/writeback states.
- Produces the packed 14-bit ControlLine word each cycle. The downstream control-line unpacking block splits this word into individual datapath enables and selects.
- Sits between the instruction register's opcode field and the datapath. Also stalls on a simple memory ready handshake.

---
 rtl/multicycle_control_fsm.sv | 148 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control unit: steps each instruction through fetch, decode,
// execute, memory and writeback, and drives the packed 14-bit control word.
// Ports: clk, reset (async, active high); OPCODE (from IR, valid from DECODE);
//        MEM_READY (memory done this cycle); ControlLine (packed control word);
//        STATE (current state, debug); HALTED (in HALT); ILLEGAL (sticky,
//        undefined opcode decoded).
// Latency: ControlLine is combinational from state (plus MEM_READY in FETCH).
// Backpressure: FETCH, MEMREAD and MEMWR hold until MEM_READY is high.
module multicycle_control_fsm #(
  parameter int             OPW         = 4,
  parameter logic [OPW-1:0] HALT_OPCODE = OPW'(4'hF)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] OPCODE,
  input  logic           MEM_READY,
  output logic [13:0]    ControlLine,
  output logic [3:0]     STATE,
  output logic           HALTED,
  output logic           ILLEGAL
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_LW    = OPW'(2);
  localparam logic [OPW-1:0] OP_SW    = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(4);
  localparam logic [OPW-1:0] OP_J     = OPW'(5);

  // Control words, field order:
  // PCWRITE, IRWRITE, WRITEPORTSELECT, WRITEDATASELECT[1:0], REGWRITE,
  // ALUSRCA, ALUSRCB[1:0], ALUOP[1:0], PCSRC, MEMWRITE, BRANCH
  // FETCH base word: ALU computes PC+4. PCWRITE/IRWRITE are added from MEM_READY.
  localparam logic [13:0] CW_FETCH    = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
  // DECODE: ALU precomputes the branch target PC+offset.
  localparam logic [13:0] CW_DECODE   = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
  // Effective address = reg + immediate; held through MEMREAD so the address is stable.
  localparam logic [13:0] CW_ADDR     = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] CW_MEMWB    = {1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] CW_MEMWR    = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] CW_RTYPE_EX = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] CW_RTYPE_WB = {1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] CW_BRANCH   = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1};
  localparam logic [13:0] CW_JUMP     = {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
  localparam logic [13:0] CW_ADDI_WB  = {1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

  state_t         state;
  state_t         next_state;
  logic [OPW-1:0] opcode_q;
  logic           illegal_q;
  logic           op_known;
  logic [13:0]    control_word;

  // Opcodes with a defined execution path; anything else parks in HALT as illegal.
  assign op_known = (OPCODE == OP_RTYPE) || (OPCODE == OP_ADDI) ||
                    (OPCODE == OP_LW)    || (OPCODE == OP_SW)   ||
                    (OPCODE == OP_BEQ)   || (OPCODE == OP_J)    ||
                    (OPCODE == HALT_OPCODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      // Opcode captured once at DECODE so later IR changes cannot steer MEMADDR.
      if (state == S_DECODE) begin
        opcode_q <= OPCODE;
        if (!op_known) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = MEM_READY ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (OPCODE == OP_RTYPE)                        next_state = S_RTYPE_EX;
        else if (OPCODE == OP_ADDI)                    next_state = S_ADDI_EX;
        else if (OPCODE == OP_LW || OPCODE == OP_SW)   next_state = S_MEMADDR;
        else if (OPCODE == OP_BEQ)                     next_state = S_BRANCH;
        else if (OPCODE == OP_J)                       next_state = S_JUMP;
        else                                           next_state = S_HALT;
      end
      // Only LW and SW reach MEMADDR, so anything not LW is a store.
      S_MEMADDR:  next_state = (opcode_q == OP_LW) ? S_MEMREAD : S_MEMWR;
      S_MEMREAD:  next_state = MEM_READY ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = MEM_READY ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: next_state = S_RTYPE_WB;
      S_RTYPE_WB: next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_ADDI_EX:  next_state = S_ADDI_WB;
      S_ADDI_WB:  next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    control_word = '0;
    case (state)
      // PC and IR update only in the cycle memory delivers the instruction.
      S_FETCH:    control_word = CW_FETCH | {MEM_READY, MEM_READY, 12'h000};
      S_DECODE:   control_word = CW_DECODE;
      S_MEMADDR:  control_word = CW_ADDR;
      S_MEMREAD:  control_word = CW_ADDR;
      S_MEMWB:    control_word = CW_MEMWB;
      S_MEMWR:    control_word = CW_MEMWR;
      S_RTYPE_EX: control_word = CW_RTYPE_EX;
      S_RTYPE_WB: control_word = CW_RTYPE_WB;
      S_BRANCH:   control_word = CW_BRANCH;
      S_JUMP:     control_word = CW_JUMP;
      S_ADDI_EX:  control_word = CW_ADDR;
      S_ADDI_WB:  control_word = CW_ADDI_WB;
      S_HALT:     control_word = '0;
      default:    control_word = '0;
    endcase
  end

  // Reset gates the word directly so no write enable survives between edges.
  assign ControlLine = reset ? 14'h0000 : control_word;
  assign STATE       = state;
  assign HALTED      = (state == S_HALT);
  assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: builds the expected per-cycle trace of each
// instruction from the instruction timing rules, then plays it against the DUT.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  OPCODE;
  logic        MEM_READY;
  logic [13:0] ControlLine;
  logic [3:0]  STATE;
  logic        HALTED;
  logic        ILLEGAL;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  st;
    logic [13:0] cl;
    logic        rdy;
    logic [3:0]  opc;
    logic        hlt;
    logic        ill;
  } cyc_t;

  cyc_t plan[$];

  multicycle_control_fsm #(.OPW(4), .HALT_OPCODE(4'hF)) dut (
    .clk         (clk),
    .reset       (reset),
    .OPCODE      (OPCODE),
    .MEM_READY   (MEM_READY),
    .ControlLine (ControlLine),
    .STATE       (STATE),
    .HALTED      (HALTED),
    .ILLEGAL     (ILLEGAL)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input int st, input logic [13:0] cl, input logic rdy,
                      input logic [3:0] opc, input logic ill);
    cyc_t c;
    c.st = 4'(st); c.cl = cl; c.rdy = rdy; c.opc = opc;
    c.hlt = (st == 12); c.ill = ill;
    plan.push_back(c);
  endtask

  // Expected trace of one instruction: fw fetch waits, mw memory waits.
  // Outside the handshake states MEM_READY and (after DECODE) OPCODE are random.
  task automatic build(input logic [3:0] op, input int fw, input int mw, input int halt_len);
    bit ill;
    ill = !(op <= 4'd5 || op == 4'hF);
    for (int k = 0; k < fw; k++) push(0, 14'h0020, 1'b0, rnd4(), 1'b0);
    push(0, 14'h3020, 1'b1, op, 1'b0);
    push(1, 14'h0060, rnd1(), op, 1'b0);
    case (op)
      4'd0: begin push(6, 14'h0090, rnd1(), rnd4(), 1'b0); push(7, 14'h0900, rnd1(), rnd4(), 1'b0); end
      4'd1: begin push(10, 14'h00C0, rnd1(), rnd4(), 1'b0); push(11, 14'h0100, rnd1(), rnd4(), 1'b0); end
      4'd2: begin
        push(2, 14'h00C0, rnd1(), rnd4(), 1'b0);
        for (int k = 0; k < mw; k++) push(3, 14'h00C0, 1'b0, rnd4(), 1'b0);
        push(3, 14'h00C0, 1'b1, rnd4(), 1'b0);
        push(4, 14'h0300, rnd1(), rnd4(), 1'b0);
      end
      4'd3: begin
        push(2, 14'h00C0, rnd1(), rnd4(), 1'b0);
        for (int k = 0; k < mw; k++) push(5, 14'h00C2, 1'b0, rnd4(), 1'b0);
        push(5, 14'h00C2, 1'b1, rnd4(), 1'b0);
      end
      4'd4: push(8, 14'h008D, rnd1(), rnd4(), 1'b0);
      4'd5: push(9, 14'h2004, rnd1(), rnd4(), 1'b0);
      default: for (int k = 0; k < halt_len; k++) push(12, 14'h0000, rnd1(), rnd4(), ill);
    endcase
  endtask

  // Called just after a rising edge; each entry is one clock cycle.
  task automatic play();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      MEM_READY = c.rdy;
      OPCODE    = c.opc;
      @(negedge clk);
      chk("state", 16'(STATE), 16'(c.st));
      chk("ctrl", 16'(ControlLine), 16'(c.cl));
      chk("halted", 16'(HALTED), 16'(c.hlt));
      chk("illegal", 16'(ILLEGAL), 16'(c.ill));
      @(posedge clk);
      #1;
    end
  endtask

  // Reset raised between edges; outputs must react before any clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ctrl", 16'(ControlLine), 16'h0000);
    chk("rst_state", 16'(STATE), 16'h0000);
    chk("rst_illegal", 16'(ILLEGAL), 16'h0000);
    chk("rst_halted", 16'(HALTED), 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    reset = 1'b1;
    MEM_READY = 1'b1;
    OPCODE = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_ctrl", 16'(ControlLine), 16'h0000);
    chk("por_state", 16'(STATE), 16'h0000);
    chk("por_halted", 16'(HALTED), 16'h0000);
    chk("por_illegal", 16'(ILLEGAL), 16'h0000);
    reset = 1'b0;

    // Directed: R-type, LW with 2 waits, SW with 3 waits, fetch waits + BEQ, J.
    build(4'd0, 0, 0, 0);
    build(4'd2, 0, 2, 0);
    build(4'd3, 0, 3, 0);
    build(4'd4, 3, 0, 0);
    build(4'd5, 0, 0, 0);
    build(4'd1, 1, 0, 0);
    build(4'd7, 0, 0, 12);
    play();
    async_reset();
    build(4'hF, 0, 0, 5);
    play();
    async_reset();

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        op = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(6, 14));
        build(op, $urandom_range(0, 3), 0, $urandom_range(1, 4));
        play();
        async_reset();
      end else begin
        build(4'($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        play();
      end
    end

    // Abort an R-type in its writeback cycle, then confirm normal resumption.
    build(4'd0, 0, 0, 0);
    void'(plan.pop_back());
    play();
    MEM_READY = 1'b1;
    OPCODE = 4'd0;
    chk("wb_state", 16'(STATE), 16'h0007);
    async_reset();
    build(4'd0, 1, 0, 0);
    build(4'd5, 0, 0, 0);
    play();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
